// File: rtl/vga_grid_pkg.sv
// Shared types, colour constants, default VGA timing and the cell-state palette
// for the VGA grid renderer.
package vga_grid_pkg;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_GREY   = 12'h222;
  localparam logic [11:0] RGB_RED    = 12'hF00;
  localparam logic [11:0] RGB_BLUE   = 12'h00F;
  localparam logic [11:0] RGB_GREEN  = 12'h0F0;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;

  localparam int unsigned DEF_H_ACTIVE     = 640;
  localparam int unsigned DEF_H_FP         = 16;
  localparam int unsigned DEF_H_SYNC       = 96;
  localparam int unsigned DEF_H_BP         = 48;
  localparam int unsigned DEF_V_ACTIVE     = 480;
  localparam int unsigned DEF_V_FP         = 10;
  localparam int unsigned DEF_V_SYNC       = 2;
  localparam int unsigned DEF_V_BP         = 33;
  localparam bit          DEF_SYNC_ACTIVE_LOW = 1'b1;
  localparam int unsigned DEF_GRID_N       = 3;
  localparam int unsigned DEF_STATE_W      = 2;
  localparam int unsigned DEF_CELL_PX      = 128;
  localparam int unsigned DEF_ORIGIN_X     = 128;
  localparam int unsigned DEF_ORIGIN_Y     = 48;
  localparam int unsigned DEF_LINE_PX      = 4;
  localparam int unsigned DEF_BLINK_FRAMES = 30;

  // Pixel class decided in stage 1; stage 2 turns it into a colour.
  typedef enum logic [1:0] {
    PIX_BLANK,
    PIX_LINE,
    PIX_CURSOR,
    PIX_CELL
  } pix_kind_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic logic [11:0] state_rgb(input int unsigned st);
    logic [11:0] c;
    case (st)
      0:       c = RGB_GREY;
      1:       c = RGB_RED;
      2:       c = RGB_BLUE;
      3:       c = RGB_GREEN;
      default: c = RGB_WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_grid_renderer_timing.sv
// Free-running horizontal/vertical raster counters with raw (active-high)
// in-sync flags decoded from the current counter values.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_W     = $clog2(H_TOTAL),
  localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
  input  logic           pixel_clock,
  input  logic           reset,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           hs_c,
  output logic           vs_c
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // v advances only on the last pixel of a line.
  always_comb begin
    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (32'(h_q) == H_TOTAL - 1) begin
      h_d = '0;
      if (32'(v_q) == V_TOTAL - 1) begin
        v_d = '0;
      end else begin
        v_d = v_q + V_W'(1);
      end
    end
  end

  assign h_cnt = h_q;
  assign v_cnt = v_q;
  assign hs_c  = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
  assign vs_c  = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);

endmodule

// File: rtl/vga_grid_renderer.sv
// N x N game-grid renderer: frame-synchronous board snapshot, blinking cursor,
// two-stage pixel pipeline with syncs and frame_start aligned to colour.
module vga_grid_renderer
  import vga_grid_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned H_FP            = DEF_H_FP,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BP            = DEF_H_BP,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned V_FP            = DEF_V_FP,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BP            = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int unsigned GRID_N          = DEF_GRID_N,
  parameter int unsigned STATE_W         = DEF_STATE_W,
  parameter int unsigned CELL_PX         = DEF_CELL_PX,
  parameter int unsigned ORIGIN_X        = DEF_ORIGIN_X,
  parameter int unsigned ORIGIN_Y        = DEF_ORIGIN_Y,
  parameter int unsigned LINE_PX         = DEF_LINE_PX,
  parameter int unsigned BLINK_FRAMES    = DEF_BLINK_FRAMES
) (
  input  logic                                  pixel_clock,
  input  logic                                  reset,
  input  logic [GRID_N*GRID_N*STATE_W-1:0]      cells,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]      cursor_idx,
  input  logic                                  cursor_en,
  output logic [3:0]                            VGA_R,
  output logic [3:0]                            VGA_G,
  output logic [3:0]                            VGA_B,
  output logic                                  VGA_HS,
  output logic                                  VGA_VS,
  output logic                                  frame_start
);

  localparam int unsigned CELLS   = GRID_N * GRID_N;
  localparam int unsigned IDX_W   = $clog2(CELLS);
  localparam int unsigned CELLS_W = CELLS * STATE_W;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned GRID_PX = GRID_N * CELL_PX;
  localparam int unsigned OFF_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int unsigned RC_W    = $clog2(GRID_N + 1);
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Counter value one step before the grid origin, so offsets read 0 exactly at the origin.
  localparam int unsigned X_PRE   = (ORIGIN_X == 0) ? H_TOTAL - 1 : ORIGIN_X - 1;
  localparam int unsigned Y_PRE   = (ORIGIN_Y == 0) ? V_TOTAL - 1 : ORIGIN_Y - 1;

  // ---------------- stage 0: raster and offset counters ----------------
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           hs_raw_c;
  logic           vs_raw_c;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs_c        (hs_raw_c),
    .vs_c        (vs_raw_c)
  );

  logic [OFF_W-1:0] x_off_q, x_off_d;
  logic [OFF_W-1:0] y_off_q, y_off_d;
  logic [RC_W-1:0]  col_q, col_d;
  logic [RC_W-1:0]  row_q, row_d;
  logic             line_end;

  assign line_end = (32'(h_cnt) == H_TOTAL - 1);

  // col/row saturate at GRID_N so they never wrap back into the grid.
  always_comb begin
    x_off_d = x_off_q + OFF_W'(1);
    col_d   = col_q;
    y_off_d = y_off_q;
    row_d   = row_q;
    if (32'(h_cnt) == X_PRE) begin
      x_off_d = '0;
      col_d   = '0;
    end else if (32'(x_off_q) == CELL_PX - 1) begin
      x_off_d = '0;
      if (32'(col_q) != GRID_N) col_d = col_q + RC_W'(1);
    end
    if (line_end) begin
      if (32'(v_cnt) == Y_PRE) begin
        y_off_d = '0;
        row_d   = '0;
      end else if (32'(y_off_q) == CELL_PX - 1) begin
        y_off_d = '0;
        if (32'(row_q) != GRID_N) row_d = row_q + RC_W'(1);
      end else begin
        y_off_d = y_off_q + OFF_W'(1);
      end
    end
  end

  // ---------------- snapshot and blink ----------------
  logic [CELLS_W-1:0] sh_cells_q, sh_cells_d;
  logic [IDX_W-1:0]   sh_cur_q, sh_cur_d;
  logic               sh_en_q, sh_en_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_q, blink_d;
  logic               snap;

  assign snap = line_end && (32'(v_cnt) == V_ACTIVE - 1);

  always_comb begin
    sh_cells_d = sh_cells_q;
    sh_cur_d   = sh_cur_q;
    sh_en_d    = sh_en_q;
    frame_d    = frame_q;
    blink_d    = blink_q;
    if (snap) begin
      sh_cells_d = cells;
      sh_cur_d   = cursor_idx;
      sh_en_d    = cursor_en;
      if (32'(frame_q) == BLINK_FRAMES - 1) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  // ---------------- stage 1: region / line / cursor / state decode ----------------
  pix_kind_t        kind_q, kind_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic             hs1_q, hs1_d;
  logic             vs1_q, vs1_d;
  logic             fs1_q, fs1_d;
  int unsigned      cell_k;
  logic             in_act;
  logic             in_grid;
  logic             on_line;
  logic             in_band;
  logic             cur_hit;

  always_comb begin
    cell_k  = 32'(row_q) * GRID_N + 32'(col_q);
    in_act  = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    in_grid = (32'(h_cnt) >= ORIGIN_X) && (32'(h_cnt) < ORIGIN_X + GRID_PX) &&
              (32'(v_cnt) >= ORIGIN_Y) && (32'(v_cnt) < ORIGIN_Y + GRID_PX);
    on_line = ((col_q != '0) && (32'(x_off_q) < LINE_PX)) ||
              ((row_q != '0) && (32'(y_off_q) < LINE_PX));
    in_band = (32'(x_off_q) < 2 * LINE_PX) || (32'(y_off_q) < 2 * LINE_PX) ||
              (32'(x_off_q) >= CELL_PX - LINE_PX) || (32'(y_off_q) >= CELL_PX - LINE_PX);
    // An out-of-range cursor index never equals an in-grid cell, so nothing is drawn.
    cur_hit = sh_en_q && blink_q && (32'(sh_cur_q) == cell_k);

    state_d = '0;
    for (int unsigned k = 0; k < CELLS; k++) begin
      if (cell_k == k) state_d = sh_cells_q[k*STATE_W +: STATE_W];
    end

    kind_d = PIX_BLANK;
    if (in_act && in_grid) begin
      if (on_line) begin
        kind_d = PIX_LINE;
      end else if (cur_hit && in_band) begin
        kind_d = PIX_CURSOR;
      end else begin
        kind_d = PIX_CELL;
      end
    end

    hs1_d = hs_raw_c;
    vs1_d = vs_raw_c;
    fs1_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // ---------------- stage 2: colour and sync pins ----------------
  rgb_t rgb_q, rgb_d;
  logic hs2_q, hs2_d;
  logic vs2_q, vs2_d;
  logic fs2_q, fs2_d;

  always_comb begin
    rgb_d = RGB_BLACK;
    case (kind_q)
      PIX_LINE:   rgb_d = RGB_WHITE;
      PIX_CURSOR: rgb_d = RGB_YELLOW;
      PIX_CELL:   rgb_d = state_rgb(32'(state_q));
      default:    rgb_d = RGB_BLACK;
    endcase
    hs2_d = hs1_q ^ SYNC_ACTIVE_LOW;
    vs2_d = vs1_q ^ SYNC_ACTIVE_LOW;
    fs2_d = fs1_q;
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      x_off_q    <= '0;
      y_off_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sh_cells_q <= '0;
      sh_cur_q   <= '0;
      sh_en_q    <= 1'b0;
      frame_q    <= '0;
      blink_q    <= 1'b1;
      kind_q     <= PIX_BLANK;
      state_q    <= '0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      fs1_q      <= 1'b0;
      rgb_q      <= RGB_BLACK;
      hs2_q      <= SYNC_ACTIVE_LOW;
      vs2_q      <= SYNC_ACTIVE_LOW;
      fs2_q      <= 1'b0;
    end else begin
      x_off_q    <= x_off_d;
      y_off_q    <= y_off_d;
      col_q      <= col_d;
      row_q      <= row_d;
      sh_cells_q <= sh_cells_d;
      sh_cur_q   <= sh_cur_d;
      sh_en_q    <= sh_en_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      kind_q     <= kind_d;
      state_q    <= state_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      fs1_q      <= fs1_d;
      rgb_q      <= rgb_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      fs2_q      <= fs2_d;
    end
  end

  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign frame_start = fs2_q;

endmodule
